mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch requester (IF) and the load/store requester (D, MEM stage).
- Sequences each access through the memory's ready-drop/ready-rise handshake and returns read data to the granted requester with a one-cycle done pulse.
- Sits between the pipeline front-end / MEM stage and the memory controller. The pipeline stall logic stalls on (req & ~done).

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_D_STREAK, 4, consecutive D grants allowed while IF waits before IF is forced ahead (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
if_req  input  1  IF read request, held until if_done
if_addr  input  ADDR_WIDTH  IF read address
if_rdata  output  DATA_WIDTH  IF read data, valid when if_done=1, held until next IF completion
if_done  output  1  one-cycle IF completion pulse
d_req  input  1  D request, held until d_done
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_WIDTH  D address
d_wdata  input  DATA_WIDTH  D write data
d_rdata  output  DATA_WIDTH  D read data, valid when d_done=1 and the access was a read, held until next D read completion
d_done  output  1  one-cycle D completion pulse
mem_start  output  1  one-cycle command strobe to memory
mem_we  output  1  write enable to memory, held for the whole transaction
mem_addr  output  ADDR_WIDTH  memory address, held for the whole transaction
mem_wdata  output  DATA_WIDTH  memory write data, held for the whole transaction
mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle mem_ready rises
mem_ready  input  1  1 = memory idle; drops after mem_start; rises when the access is complete
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (asynchronous, any state including mid-transaction):
  - state = IDLE; all outputs 0.
  - if_rdata/d_rdata = 0; streak counter = 0; grant register = IF.
  - The in-flight memory access is abandoned; no done pulse is issued for it.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If (if_req | d_req) & mem_ready: arbitrate, latch the grantee, addr, we and wdata into the mem_* registers, go to ISSUE.
  - If mem_ready=0, stay in IDLE and do not arbitrate.
  - IF requests always latch mem_we=0 and mem_wdata=0.
- Arbitration:
  - D wins by default.
  - IF wins if d_req=0, or if if_req=1 and streak == MAX_D_STREAK.
- Streak counter (4 bits), updated only at an IDLE grant:
  - D granted while if_req=1: increment, saturating at MAX_D_STREAK.
  - IF granted, or if_req=0 at the grant: clear to 0.
- ISSUE: mem_start=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: on mem_ready=0, go to WAIT_DONE; otherwise remain. The memory may take any number of cycles to drop ready.
- WAIT_DONE: on mem_ready=1, capture mem_rdata into the grantee's rdata register (reads only; writes leave d_rdata unchanged), then go to RESP.
- RESP:
  - Pulse the grantee's done for one cycle; go to IDLE.
  - Arbitration in the following IDLE cycle sees the requester's updated req (≥1 idle cycle between transactions).
- Minimum latency: grant at cycle 0 (IDLE), mem_start at cycle 1. If mem_ready drops at cycle 2 and rises at cycle 3, done is asserted at cycle 4.
- mem_we, mem_addr and mem_wdata are stable from ISSUE through RESP.
- Requesters changing addr/wdata/we, or dropping req, mid-transaction have no effect; the latched transaction completes and done still pulses.
- if_done and d_done are never high in the same cycle.
- busy = 1 in every state except IDLE.

Test Plan:
1. Lone IF read: if_req=1, if_addr=0x100; memory drops ready 1 cycle after mem_start, rises 3 cycles later with 0xDEADBEEF -> mem_start is a single pulse with mem_addr=0x100, mem_we=0; if_done pulses once; if_rdata=0xDEADBEEF; d_done stays 0.
2. D write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 held until RESP; d_done pulses; d_rdata unchanged (0).
3. Simultaneous requests: if_req and d_req high together -> D is served first; IF is granted in the first IDLE cycle after d_done; exactly one done per transaction.
4. Starvation guard, MAX_D_STREAK=4: d_req and if_req held high continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF; streak reads 0 after each IF grant.
5. Slow memory: mem_ready stays high for 5 cycles after mem_start, then drops, then rises after 10 cycles -> FSM waits in WAIT_BUSY then WAIT_DONE; no second mem_start; done pulses exactly once, one cycle after ready rises.
6. Reset mid-access: assert rst during WAIT_DONE -> all outputs 0 immediately; no done pulse; after release with if_req=1 and mem_ready=1, a fresh IF transaction starts normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (D).
// D wins by default; IF is forced ahead after MAX_D_STREAK consecutive D grants it sat through.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t                r_state;
  logic                  r_grant_d;
  logic [3:0]            r_streak;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_if_done;
  logic                  r_d_done;
  logic                  r_mem_start;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_busy;

  logic w_req_any;
  logic w_grant_if;

  assign w_req_any  = if_req | d_req;
  assign w_grant_if = if_req & (~d_req | (r_streak == STREAK_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_d   <= 1'b0;
      r_streak    <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_start <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_start <= 1'b0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_any && mem_ready) begin
            r_state     <= ISSUE;
            r_busy      <= 1'b1;
            r_mem_start <= 1'b1;
            if (w_grant_if) begin
              r_grant_d   <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
              r_streak    <= '0;
            end else begin
              r_grant_d   <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              // Only grants that make IF wait count toward the streak.
              if (!if_req)
                r_streak <= '0;
              else if (r_streak < STREAK_MAX)
                r_streak <= r_streak + 4'd1;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mem_ready)
            r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mem_ready) begin
            r_state <= RESP;
            if (r_grant_d) begin
              if (!r_mem_we)
                r_d_rdata <= mem_rdata;
              r_d_done <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_done  <= 1'b1;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_done   = r_if_done;
  assign d_rdata   = r_d_rdata;
  assign d_done    = r_d_done;
  assign mem_start = r_mem_start;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
